// File: rtl/kf_pkg.sv
// Shared constants, FSM encoding and cfg address map for the Kalman predict scheduler.
package kf_pkg;
    localparam int KF_DW    = 32;
    localparam int KF_FRAC  = 16;
    localparam int KF_N     = 4;
    localparam int KF_TERMS = KF_N + 1;  // four A*X terms plus the B*u term per row

    localparam logic [4:0] CFG_A_BASE = 5'd0;
    localparam logic [4:0] CFG_B_BASE = 5'd16;
    localparam logic [4:0] CFG_X_BASE = 5'd20;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MAC    = 2'd1,
        S_COMMIT = 2'd2
    } kf_state_t;
endpackage

// File: rtl/kf_mac.sv
// Shared signed multiply-accumulate: full-width product, extended accumulator, load-on-clear.
module kf_mac #(
    parameter int DW = 32,
    parameter int AW = 2*DW + 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_b,
    output logic signed [AW-1:0] o_acc
);
    logic signed [2*DW-1:0] w_prod;
    logic signed [AW-1:0]   w_ext;

    assign w_prod = i_a * i_b;
    assign w_ext  = {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};

    // Clear is folded into the first term's load so a row needs no idle cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_acc <= '0;
        else if (i_en)
            o_acc <= i_clr ? w_ext : o_acc + w_ext;
    end
endmodule

// File: rtl/kf_predict_sched.sv
// Kalman predict step X' = A*X + B*u on one shared MAC (20 MAC cycles + commit).
// Optional KF_SAT_EN: saturate row results instead of wrapping.
module kf_predict_sched
    import kf_pkg::*;
#(
    parameter int DW   = KF_DW,
    parameter int FRAC = KF_FRAC,
    parameter int N    = KF_N
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_begin,
    input  logic [DW-1:0] i_u,
    input  logic          i_cfg_we,
    input  logic [4:0]    i_cfg_addr,
    input  logic [DW-1:0] i_cfg_data,
    output logic [DW-1:0] o_state0,
    output logic [DW-1:0] o_state1,
    output logic [DW-1:0] o_state2,
    output logic [DW-1:0] o_state3,
    output logic          o_valid,
    output logic          o_busy,
    output logic          o_overrun,
    output logic          o_cfg_err
);
    localparam int AW = 2*DW + 3;

    kf_state_t r_state, w_next;
    logic [N*N-1:0][DW-1:0] r_a;
    logic [N-1:0][DW-1:0]   r_b, r_x, r_xn;
    logic [DW-1:0]          r_u;
    logic [1:0]             r_row;
    logic [2:0]             r_term;
    logic                   r_valid, r_ovr, r_cerr;

    logic                   w_last, w_bterm;
    logic [DW-1:0]          w_mac_a, w_mac_b, w_row;
    logic signed [AW-1:0]   w_acc;
    logic                   w_unused;

    assign w_bterm = (r_term == 3'(KF_TERMS-1));
    assign w_last  = (r_row == 2'(N-1)) && w_bterm;
    assign w_mac_a = w_bterm ? r_b[r_row] : r_a[{r_row, r_term[1:0]}];
    assign w_mac_b = w_bterm ? r_u : r_x[r_term[1:0]];

    kf_mac #(.DW(DW), .AW(AW)) u_mac (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (r_term == 3'd0),
        .i_en  (r_state == S_MAC),
        .i_a   (w_mac_a),
        .i_b   (w_mac_b),
        .o_acc (w_acc)
    );

`ifdef KF_SAT_EN
    // Every bit above the kept window must match its sign bit, otherwise clamp.
    logic [AW-FRAC-DW:0] w_hi;
    assign w_hi     = w_acc[AW-1:FRAC+DW-1];
    assign w_row    = (&w_hi || !(|w_hi)) ? w_acc[FRAC+DW-1:FRAC]
                    : (w_acc[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
    assign w_unused = ^w_acc[FRAC-1:0];
`else
    assign w_row    = w_acc[FRAC+DW-1:FRAC];
    assign w_unused = ^{w_acc[AW-1:FRAC+DW], w_acc[FRAC-1:0]};
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_begin) w_next = S_MAC;
            S_MAC:    if (w_last)  w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_x     <= '0;
            r_xn    <= '0;
            r_u     <= '0;
            r_row   <= '0;
            r_term  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_cerr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_cfg_we) begin
                if (r_state != S_IDLE)
                    r_cerr <= 1'b1;
                else if (i_cfg_addr[4] == CFG_A_BASE[4])
                    r_a[i_cfg_addr[3:0]] <= i_cfg_data;
                else if (i_cfg_addr[4:2] == CFG_B_BASE[4:2])
                    r_b[i_cfg_addr[1:0]] <= i_cfg_data;
                else if (i_cfg_addr[4:2] == CFG_X_BASE[4:2])
                    r_x[i_cfg_addr[1:0]] <= i_cfg_data;
            end
            if (i_begin) begin
                if (r_state == S_IDLE) r_u   <= i_u;
                else                   r_ovr <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_row  <= '0;
                    r_term <= '0;
                end
                S_MAC: begin
                    // The accumulator holds the finished previous row while the next row's first term loads.
                    if (r_term == 3'd0 && r_row != 2'd0)
                        r_xn[2'(r_row - 2'd1)] <= w_row;
                    if (w_bterm) begin
                        r_term <= '0;
                        r_row  <= r_row + 2'd1;
                    end else begin
                        r_term <= r_term + 3'd1;
                    end
                end
                S_COMMIT: begin
                    r_xn[N-1] <= w_row;
                    for (int i = 0; i < N-1; i++) r_x[i] <= r_xn[i];
                    r_x[N-1] <= w_row;
                    r_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_state0  = r_x[0];
    assign o_state1  = r_x[1];
    assign o_state2  = r_x[2];
    assign o_state3  = r_x[3];
    assign o_valid   = r_valid;
    assign o_busy    = (r_state != S_IDLE);
    assign o_overrun = r_ovr;
    assign o_cfg_err = r_cerr;
endmodule

// File: tb/tb_kf_predict_sched.sv
// Directed + randomized bench for kf_predict_sched against a plain-arithmetic reference model.
module tb_kf_predict_sched;
    localparam int K_NONE = 0, K_BEGIN = 1, K_CFG = 2, K_RST = 3;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1, i_begin = 1'b0, i_cfg_we = 1'b0;
    logic [31:0] i_u = '0, i_cfg_data = '0;
    logic [4:0]  i_cfg_addr = '0;
    logic [31:0] o_state0, o_state1, o_state2, o_state3;
    logic        o_valid, o_busy, o_overrun, o_cfg_err;

    always #5 i_clk = ~i_clk;

    kf_predict_sched dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_begin(i_begin), .i_u(i_u),
        .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
        .o_state0(o_state0), .o_state1(o_state1), .o_state2(o_state2), .o_state3(o_state3),
        .o_valid(o_valid), .o_busy(o_busy), .o_overrun(o_overrun), .o_cfg_err(o_cfg_err)
    );

    int checks = 0, errors = 0;
    int ma[16], mb[4], mx[4];
    bit m_ovr, m_cerr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    function automatic void mclear();
        for (int i = 0; i < 16; i++) ma[i] = 0;
        for (int i = 0; i < 4; i++) begin mb[i] = 0; mx[i] = 0; end
        m_ovr = 0; m_cerr = 0;
    endfunction

    function automatic void mwrite(input int a, input logic [31:0] d);
        if (a < 16)      ma[a] = d;
        else if (a < 20) mb[a-16] = d;
        else if (a < 24) mx[a-20] = d;
    endfunction

    // Row r of A*X + B*u in exact arithmetic, then scaled back by 2^16.
    function automatic logic [31:0] row_res(input int r, input int u);
        logic signed [66:0] s = '0;
        logic signed [66:0] t;
        for (int c = 0; c < 4; c++) s = s + 67'(longint'(ma[r*4+c]) * longint'(mx[c]));
        s = s + 67'(longint'(mb[r]) * longint'(u));
        t = s >>> 16;
`ifdef KF_SAT_EN
        if (t > 67'sd2147483647)  return 32'h7FFFFFFF;
        if (t < -67'sd2147483648) return 32'h80000000;
`endif
        return t[31:0];
    endfunction

    task automatic chk_states(input string tag, input logic [31:0] e0, e1, e2, e3);
        chk({tag, "_s0"}, o_state0, e0);
        chk({tag, "_s1"}, o_state1, e1);
        chk({tag, "_s2"}, o_state2, e2);
        chk({tag, "_s3"}, o_state3, e3);
    endtask

    task automatic do_reset();
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        mclear();
    endtask

    task automatic cfg_write(input int a, input logic [31:0] d);
        i_cfg_we = 1'b1; i_cfg_addr = a[4:0]; i_cfg_data = d;
        tick();
        i_cfg_we = 1'b0;
        mwrite(a, d);
    endtask

    // One predict step; optionally inject an event sampled at edge E0+inj_k.
    task automatic step(input string tag, input logic [31:0] u, input int inj_k,
                        input int kind, input int inj_a, input logic [31:0] inj_d);
        logic [31:0] ex[4];
        int nval = 0, vpos = -1;
        bit aborted = 0;
        i_u = u; i_begin = 1'b1;
        if (inj_k == 0 && kind == K_CFG) begin
            i_cfg_we = 1'b1; i_cfg_addr = inj_a[4:0]; i_cfg_data = inj_d;
        end
        tick();
        i_begin = 1'b0; i_cfg_we = 1'b0;
        if (inj_k == 0 && kind == K_CFG) mwrite(inj_a, inj_d);
        for (int r = 0; r < 4; r++) ex[r] = row_res(r, u);
        chk({tag, "_busy_start"}, o_busy, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            if (k == inj_k) begin
                case (kind)
                    K_BEGIN: i_begin = 1'b1;
                    K_CFG:   begin i_cfg_we = 1'b1; i_cfg_addr = inj_a[4:0]; i_cfg_data = inj_d; end
                    K_RST:   i_rst = 1'b1;
                    default: ;
                endcase
            end
            tick();
            i_begin = 1'b0; i_cfg_we = 1'b0; i_rst = 1'b0;
            if (k == inj_k) begin
                if (kind == K_BEGIN) m_ovr = 1;
                if (kind == K_CFG && inj_k > 0) m_cerr = 1;
                if (kind == K_RST) begin
                    aborted = 1;
                    mclear();
                    chk({tag, "_rst_busy"}, o_busy, 1'b0);
                    chk({tag, "_rst_valid"}, o_valid, 1'b0);
                    chk_states({tag, "_rst"}, 0, 0, 0, 0);
                end
            end
            if (o_valid === 1'b1) begin
                nval++;
                if (vpos < 0) vpos = k;
                chk({tag, "_busy_commit"}, o_busy, 1'b0);
                chk_states(tag, ex[0], ex[1], ex[2], ex[3]);
            end
        end
        chk({tag, "_nvalid"}, nval, aborted ? 0 : 1);
        if (!aborted) begin
            chk({tag, "_vpos"}, vpos, 21);
            chk_states({tag, "_hold"}, ex[0], ex[1], ex[2], ex[3]);
            for (int r = 0; r < 4; r++) mx[r] = ex[r];
        end
        chk({tag, "_ovr"}, o_overrun, m_ovr);
        chk({tag, "_cerr"}, o_cfg_err, m_cerr);
    endtask

    function automatic logic [31:0] rnd();
        logic [31:0] d = $urandom();
        if ($urandom_range(0, 1) == 1) d = {{12{d[19]}}, d[19:0]};
        return d;
    endfunction

    initial begin
        mclear();
        tick(); tick();
        i_rst = 1'b0;
        chk_states("reset", 0, 0, 0, 0);
        chk("reset_valid", o_valid, 1'b0);
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_ovr", o_overrun, 1'b0);
        chk("reset_cerr", o_cfg_err, 1'b0);

        // Identity A, zero B, unit X
        for (int r = 0; r < 4; r++) begin
            cfg_write(r*5, 32'h00010000);
            cfg_write(20 + r, 32'h00010000);
        end
        step("ident", 32'h12345678, -1, K_NONE, 0, 0);
        chk_states("ident_const", 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);

        // A=0, B=[1..4], u=0.5
        do_reset();
        for (int r = 0; r < 4; r++) cfg_write(16 + r, 32'((r + 1) << 16));
        step("bu", 32'h00008000, -1, K_NONE, 0, 0);
        chk_states("bu_const", 32'h00008000, 32'h00010000, 32'h00018000, 32'h00020000);

        // Overflow of row 0
        do_reset();
        cfg_write(0, 32'h00020000);
        cfg_write(20, 32'h40000000);
        step("ovf", 32'h0, -1, K_NONE, 0, 0);
`ifdef KF_SAT_EN
        chk("ovf_const", o_state0, 32'h7FFFFFFF);
`else
        chk("ovf_const", o_state0, 32'h80000000);
`endif

        // Random configuration used by the protocol tests
        do_reset();
        for (int a = 0; a < 24; a++) cfg_write(a, rnd());
        step("overrun", rnd(), 5, K_BEGIN, 0, 0);
        step("overrun_sticky", rnd(), -1, K_NONE, 0, 0);
        step("begin_in_commit", rnd(), 21, K_BEGIN, 0, 0);
        tick();
        chk("begin_in_commit_idle", o_busy, 1'b0);
        do_reset();
        chk("ovr_cleared", o_overrun, 1'b0);

        for (int a = 0; a < 24; a++) cfg_write(a, rnd());
        step("cfg_busy", rnd(), 3, K_CFG, 0, 32'hDEADBEEF);
        step("cfg_busy_next", rnd(), -1, K_NONE, 0, 0);
        step("begin_with_cfg", rnd(), 0, K_CFG, 0, rnd());
        step("abort", rnd(), 10, K_RST, 0, 0);
        chk("abort_cerr", o_cfg_err, 1'b0);

        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 32; a++) if ($urandom_range(0, 2) != 0) cfg_write(a, rnd());
            step($sformatf("rand%0d", it), rnd(), -1, K_NONE, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kf_predict_sched.md
KF_PREDICT_SCHED -- requirements
Module: kf_predict_sched

Interface
REQ-001 SHALL have parameter DW, default 32: data width, signed fixed point.
REQ-002 SHALL have parameter FRAC, default 16: fraction bits (Q16.16).
REQ-003 SHALL have parameter N, default 4: state count (fixed; other values unsupported).
REQ-004 SHALL have port i_clk  in  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port i_begin  in  1: sample strobe; starts one predict step.
REQ-007 SHALL have port i_u  in  DW: control input, latched when a step starts.
REQ-008 SHALL have port i_cfg_we  in  1: coefficient write enable.
REQ-009 SHALL have port i_cfg_addr  in  5: write address.
REQ-010 SHALL have port i_cfg_data  in  DW: write data.
REQ-011 SHALL have ports o_state0..o_state3  out  DW each: committed states X0..X3 (VCpv, IL1, IL2, VCout).
REQ-012 SHALL have port o_valid  out  1: one-cycle pulse on each new state commit.
REQ-013 SHALL have port o_busy  out  1: high while a step is in progress.
REQ-014 SHALL have port o_overrun  out  1: sticky flag, i_begin received while busy.
REQ-015 SHALL have port o_cfg_err  out  1: sticky flag, cfg write attempted while busy.

Function
REQ-016 SHALL compute X' = A*X + B*u using one shared multiply-accumulate, one MAC per cycle.
REQ-017 SHALL use the cfg address map: 0-15 = A[r][c] at r*4+c; 16-19 = B[r]; 20-23 = X seed; 24-31 writes ignored.
REQ-018 SHALL accept cfg writes only in IDLE; a write while busy is dropped and sets o_cfg_err.
REQ-019 SHALL use the FSM states IDLE, MAC, COMMIT.
REQ-020 SHALL move IDLE->MAC on i_begin=1, latching i_u.
REQ-021 SHALL run MAC for 20 cycles: for each row r=0..3, terms c=0..3 (A[r][c]*X[c]), then B[r]*u.
REQ-022 SHALL move MAC->COMMIT after the 20th MAC cycle, then COMMIT->IDLE.
REQ-023 SHALL form each product as a full 2*DW signed value, accumulate it in a 2*DW+3-bit accumulator, and clear the accumulator at the start of each row.
REQ-024 SHALL form each row result as acc[FRAC+DW-1:FRAC] (truncation), stored in shadow buffer Xn[r].
REQ-025 SHALL read only old X values during MAC; X<=Xn for all four rows simultaneously in COMMIT.
REQ-026 SHALL follow this timing, with i_begin sampled at edge E0: o_busy high from E0+1; COMMIT occupies the cycle after E0+20; o_state* update and o_valid=1 for exactly the one cycle after E0+21; o_busy low from E0+21.
REQ-027 SHALL, when i_begin=1 while busy, ignore it and set o_overrun.
REQ-028 SHALL, when i_begin=1 in the same cycle as COMMIT, ignore it and set o_overrun.
REQ-029 SHALL, when i_begin=1 in the same cycle as i_cfg_we in IDLE, perform the write first; the step uses the new value.
REQ-030 SHALL hold o_state* between commits.

Reset
REQ-031 SHALL, on i_rst=1, clear A, B, X, Xn, the accumulator, latched u and both sticky flags to 0, and set the FSM to IDLE.
REQ-032 SHALL reset all outputs to 0.
REQ-033 SHALL, on reset mid-step, abort the step with no o_valid and no partial commit; i_rst dominates i_begin and i_cfg_we.

Configuration
REQ-034 SHALL, with KF_SAT_EN defined, saturate each row result to [-2^(DW-1), 2^(DW-1)-1] before storing it to Xn.
REQ-035 SHALL, without KF_SAT_EN, wrap (plain truncation).

Structure
REQ-036 SHALL place DW, FRAC, N, the FSM state enum and the cfg address-map constants in the shared package kf_pkg.
REQ-037 SHALL implement the multiply-accumulate as sub-module kf_mac, with ports i_clk, i_rst, i_clr, i_en, i_a, i_b, o_acc.

Verification
REQ-038 SHALL cover: A=identity (0x00010000 diagonal), B=0, X seeded 0x00010000 each, i_begin -> o_valid at E0+22, all states 0x00010000.
REQ-039 SHALL cover: A=0, B=[1,2,3,4] in Q16.16, u=0x00008000 -> states 0x00008000, 0x00010000, 0x00018000, 0x00020000.
REQ-040 SHALL cover: A[0][0]=0x00020000, X0=0x40000000, others 0 -> o_state0=0x7FFFFFFF with KF_SAT_EN, 0x80000000 without.
REQ-041 SHALL cover: second i_begin at E0+5 -> single o_valid, o_overrun=1 and stays 1 until reset.
REQ-042 SHALL cover: i_rst at E0+10 -> o_busy=0 and states 0 next cycle, no o_valid.
REQ-043 SHALL cover: cfg write to addr 0 at E0+3 -> o_cfg_err=1, A[0][0] unchanged on the next step.
